// File: rtl/req_encoder_pkg.sv
// Shared constants and types for the 8-to-3 sequential request encoder.
package req_encoder_pkg;

  localparam int CODE_W = 3;
  localparam int N_REQ  = 2 ** CODE_W;

  // IDLE: no code presented. HOLD: a code is presented and waits for ready.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // One-hot mask for a code index.
  function automatic logic [N_REQ-1:0] code_onehot(input logic [CODE_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/prio_enc_8x3.sv
// Combinational priority encoder with a movable starting index.
// The search starts at 'start' and walks downward, wrapping from 0 to 7.
// With start tied to 7 this is a plain fixed-priority encoder (bit 7 highest).
module prio_enc_8x3
  import req_encoder_pkg::*;
(
  input  logic [N_REQ-1:0]  cand,
  input  logic [CODE_W-1:0] start,
  output logic [CODE_W-1:0] sel,
  output logic              any
);

  // Candidate index for each search offset; 3-bit arithmetic gives the wrap.
  logic [CODE_W-1:0] idx_w [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_idx
      assign idx_w[gi] = start - CODE_W'(gi);
    end
  endgenerate

  // Scan from the farthest offset to the nearest so the nearest hit wins.
  always_comb begin
    sel = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (cand[idx_w[i]]) begin
        sel = idx_w[i];
      end
    end
  end

  assign any = |cand;

endmodule

// File: rtl/req_encoder_8x3.sv
// Sequential 8-to-3 request encoder.
// Rising edges on req are captured into a pending register; one pending
// index at a time is presented on code with a valid/ready handshake.
// Optional build macro REQ_ENCODER_ROUND_ROBIN_EN: the search for the next
// grant starts just below the last granted index instead of at bit 7.
module req_encoder_8x3
  import req_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  input  logic              clr,
  input  logic              code_ready,
  output logic              code_valid,
  output logic [CODE_W-1:0] code,
  output logic [N_REQ-1:0]  pending,
  output logic              overflow
);

  logic [N_REQ-1:0]  req_dly_q;
  logic [N_REQ-1:0]  pending_q, pending_d;
  logic              overflow_d, overflow_q;
  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;

  logic [N_REQ-1:0]  rise;
  logic              ack;
  logic [N_REQ-1:0]  ack_mask;
  logic [CODE_W-1:0] sel;
  logic [CODE_W-1:0] start;
  logic              any;
  logic              load;

  // Event capture: new rises are merged in, the acked bit is retired.
  always_comb begin
    rise       = req & ~req_dly_q;
    ack        = valid_q & code_ready;
    ack_mask   = ack ? code_onehot(code_q) : '0;
    pending_d  = (pending_q & ~ack_mask) | rise;
    overflow_d = |(rise & pending_q & ~ack_mask);
  end

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  logic [CODE_W-1:0] last_q;

  // Search begins one below the most recent grant (reset value 0 -> start 7).
  assign start = last_q - CODE_W'(1);

  // Remember each loaded code for the next rotation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= '0;
    end else if (clr) begin
      last_q <= '0;
    end else if (load) begin
      last_q <= sel;
    end
  end
`else
  assign start = CODE_W'(N_REQ - 1);
`endif

  prio_enc_8x3 u_prio (
    .cand  (pending_d),
    .start (start),
    .sel   (sel),
    .any   (any)
  );

  // Handshake FSM: load a code from IDLE, hold it until ack, reload back-to-back.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          load    = 1'b1;
          code_d  = sel;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          if (any) begin
            load    = 1'b1;
            code_d  = sel;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // Input delay line keeps running through clr so held requests do not re-fire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_dly_q <= '0;
    end else begin
      req_dly_q <= req;
    end
  end

  // State, code and pending registers; clr wipes everything but the delay line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      code_q     <= '0;
      valid_q    <= 1'b0;
    end else if (clr) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      code_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
    end
  end

  assign code_valid = valid_q;
  assign code       = code_q;
  assign pending    = pending_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_req_encoder_8x3.sv
// Self-checking bench for req_encoder_8x3: directed scenarios plus random
// traffic, compared cycle by cycle against a set-of-events reference model.
module tb_req_encoder_8x3;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       clr;
  logic       code_ready;
  logic       code_valid;
  logic [2:0] code;
  logic [7:0] pending;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  req_encoder_8x3 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .clr        (clr),
    .code_ready (code_ready),
    .code_valid (code_valid),
    .code       (code),
    .pending    (pending),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the set of outstanding events, the code currently
  // offered to the consumer, and the last grant for rotation.
  bit [7:0] m_prev_req;
  bit [7:0] m_events;
  bit       m_offered;
  int       m_code;
  int       m_last;
  bit       m_merged;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input bit [7:0] ev);
    int s;
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    s = (m_last + 7) % 8;
`else
    s = 7;
`endif
    for (int i = 0; i < 8; i++) begin
      if (ev[(s - i + 8) % 8]) return (s - i + 8) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_prev_req = 8'h00;
    m_events   = 8'h00;
    m_offered  = 1'b0;
    m_code     = 0;
    m_last     = 0;
    m_merged   = 1'b0;
  endtask

  task automatic model_edge(input bit [7:0] r, input bit c, input bit rdy);
    bit [7:0] new_ev;
    bit [7:0] kept;
    int       nxt;
    new_ev     = r & ~m_prev_req;
    m_prev_req = r;
    if (c) begin
      m_events  = 8'h00;
      m_offered = 1'b0;
      m_code    = 0;
      m_last    = 0;
      m_merged  = 1'b0;
      return;
    end
    kept = m_events;
    if (m_offered && rdy) kept[m_code] = 1'b0;
    m_merged = |(new_ev & kept);
    m_events = kept | new_ev;
    if (!m_offered || rdy) begin
      nxt = pick(m_events);
      if (nxt >= 0) begin
        m_code    = nxt;
        m_offered = 1'b1;
        m_last    = nxt;
      end else begin
        m_offered = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    $display("%s: req=%02h clr=%0d rdy=%0d -> valid=%0d code=%0d pend=%02h ovf=%0d",
             tag, req, clr, code_ready, code_valid, code, pending, overflow);
    check({tag, "_valid"}, int'(code_valid), int'(m_offered));
    check({tag, "_code"},  int'(code),       m_code);
    check({tag, "_pend"},  int'(pending),    int'(m_events));
    check({tag, "_ovf"},   int'(overflow),   int'(m_merged));
  endtask

  // One clock: drive at the negedge, advance the model on the posedge,
  // compare at the following negedge.
  task automatic step(input string tag, input bit [7:0] r, input bit c, input bit rdy);
    req        = r;
    clr        = c;
    code_ready = rdy;
    @(posedge clk);
    model_edge(r, c, rdy);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    rst_n      = 1'b0;
    req        = 8'hFF;
    clr        = 1'b0;
    code_ready = 1'b1;
    #3;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // All lines high at reset release: drain 7 down to 0 back-to-back.
    for (int k = 0; k < 8; k++) begin
      step("drain", 8'hFF, 1'b0, 1'b1);
      check("drain_seq", int'(code), 7 - k);
    end
    step("drain_end", 8'hFF, 1'b0, 1'b1);
    check("drain_end_valid", int'(code_valid), 0);
    step("drop", 8'h00, 1'b0, 1'b0);

    // Single pulse held without ready for 5 cycles, then one ack.
    step("hold2", 8'h04, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step("hold2", 8'h00, 1'b0, 1'b0);
    check("hold2_code", int'(code), 2);
    step("ack2", 8'h00, 1'b0, 1'b1);
    check("ack2_pend", int'(pending), 0);

    // No preemption; back-to-back handoff from 1 to 6.
    step("pre1", 8'h02, 1'b0, 1'b0);
    step("pre1", 8'h00, 1'b0, 1'b0);
    step("pre6", 8'h40, 1'b0, 1'b0);
    check("nopreempt_code", int'(code), 1);
    step("pre6", 8'h00, 1'b0, 1'b1);
    check("b2b_code", int'(code), 6);
    step("pre_end", 8'h00, 1'b0, 1'b1);

    // Duplicate event on bit 3 is merged with a one-cycle overflow.
    step("ovf", 8'h08, 1'b0, 1'b0);
    step("ovf", 8'h00, 1'b0, 1'b0);
    step("ovf", 8'h08, 1'b0, 1'b0);
    check("ovf_pulse", int'(overflow), 1);
    step("ovf", 8'h00, 1'b0, 1'b0);
    step("ovf_ack", 8'h00, 1'b0, 1'b1);
    check("ovf_single", int'(code_valid), 0);

    // Rise on bit 4 on the same edge it is acked: re-presented, no overflow.
    step("reack", 8'h10, 1'b0, 1'b0);
    step("reack", 8'h00, 1'b0, 1'b0);
    step("reack", 8'h10, 1'b0, 1'b1);
    check("reack_code", int'(code), 4);
    step("reack", 8'h00, 1'b0, 1'b1);

    // clr during HOLD with the request still high: no re-fire.
    step("clr", 8'h20, 1'b0, 1'b0);
    step("clr", 8'h20, 1'b1, 1'b0);
    check("clr_pend", int'(pending), 0);
    step("clr", 8'h20, 1'b0, 1'b0);
    check("clr_nofire", int'(code_valid), 0);
    step("clr", 8'h00, 1'b0, 1'b0);

    // Rotation vs fixed priority: 0x85 pending, 7 re-rises on its own ack.
    step("rr", 8'h85, 1'b0, 1'b0);
    step("rr", 8'h00, 1'b0, 1'b0);
    step("rr", 8'h80, 1'b0, 1'b1);
`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    check("rr_next", int'(code), 2);
`else
    check("rr_next", int'(code), 7);
`endif
    for (int k = 0; k < 4; k++) step("rr_drain", 8'h00, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a handshake.
    step("arst", 8'h01, 1'b0, 1'b0);
    req = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst");
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic: sparse toggles, occasional clr, random ready.
    for (int k = 0; k < 400; k++) begin
      bit [7:0] r;
      r = req;
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      end
      step("rand", r, ($urandom_range(0, 40) == 0), $urandom_range(0, 2) != 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
